// File: rtl/cube_sched_pkg.sv
// cube_sched_pkg: shared constants and types for the cube_sched evaluator.
//   - default table geometry (DEF_NIN, DEF_NCUBE)
//   - controller state encoding (S_IDLE, S_SCAN) and its typed enum
//   - calc_cw(): width of a cube index for a given table depth
package cube_sched_pkg;

  localparam int unsigned DEF_NIN   = 12;
  localparam int unsigned DEF_NCUBE = 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  typedef enum logic [0:0] {
    StIdle = S_IDLE,
    StScan = S_SCAN
  } state_e;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int unsigned calc_cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cube_sched_match.sv
// cube_match: combinational single-cube matcher shared by every table entry.
//   in_lat_i  latched input vector
//   care_i    care mask, 1 = literal present
//   pol_i     literal polarity, 1 = positive literal
//   valid_i   entry valid bit
//   match_o   1 when the entry is valid and every present literal agrees
module cube_match #(
  parameter int unsigned NIN = 12
) (
  input  logic [NIN-1:0] in_lat_i,
  input  logic [NIN-1:0] care_i,
  input  logic [NIN-1:0] pol_i,
  input  logic           valid_i,
  output logic           match_o
);

  // An all-zero care mask reduces to constant 1 for a valid entry.
  assign match_o = valid_i & (&(~care_i | ~(in_lat_i ^ pol_i)));

endmodule

// File: rtl/cube_sched.sv
// cube_sched: sequential sum-of-products evaluator. A programmable table of
// NCUBE cubes is scanned one entry per cycle through a single shared matcher;
// the scan stops on the first (lowest-index) hit or after the last entry.
//   clk, rst          clock, synchronous active-high reset
//   start, in_vec     evaluation request and input vector (sampled in IDLE)
//   cfg_we/addr/care/pol/valid   table write port (ignored while scanning)
//   busy              high while scanning
//   done              one-cycle pulse with the result
//   o, hit, hit_idx   result, held until the next accepted start
module cube_sched
  import cube_sched_pkg::*;
#(
  parameter  int unsigned NIN   = DEF_NIN,
  parameter  int unsigned NCUBE = DEF_NCUBE,
  localparam int unsigned CW    = calc_cw(NCUBE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NIN-1:0] in_vec,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_addr,
  input  logic [NIN-1:0] cfg_care,
  input  logic [NIN-1:0] cfg_pol,
  input  logic           cfg_valid,
  output logic           busy,
  output logic           done,
  output logic           o,
  output logic           hit,
  output logic [CW-1:0]  hit_idx
);

  state_e           state_q;
  logic [CW-1:0]    idx_q;
  logic [NIN-1:0]   in_lat_q;
  logic [NIN-1:0]   care_q [NCUBE];
  logic [NIN-1:0]   pol_q  [NCUBE];
  logic [NCUBE-1:0] valid_q;
  logic             done_q;
  logic             o_q;
  logic             hit_q;
  logic [CW-1:0]    hit_idx_q;

  logic match;
  logic last;
  logic tbl_we;

  // Writes are only honoured in IDLE so the table is frozen for a whole scan.
  assign tbl_we = cfg_we && (state_q == StIdle);
  assign last   = (idx_q == CW'(NCUBE - 1));

  cube_match #(
    .NIN(NIN)
  ) u_match (
    .in_lat_i(in_lat_q),
    .care_i  (care_q[idx_q]),
    .pol_i   (pol_q[idx_q]),
    .valid_i (valid_q[idx_q]),
    .match_o (match)
  );

  // Care/polarity storage needs no reset: the valid bits gate every match.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      care_q[cfg_addr] <= cfg_care;
      pol_q[cfg_addr]  <= cfg_pol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      in_lat_q  <= '0;
      valid_q   <= '0;
      done_q    <= 1'b0;
      o_q       <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (tbl_we) begin
        valid_q[cfg_addr] <= cfg_valid;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            in_lat_q  <= in_vec;
            idx_q     <= '0;
            o_q       <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            state_q   <= StScan;
          end
        end
        StScan: begin
          if (match) begin
            o_q       <= 1'b1;
            hit_q     <= 1'b1;
            hit_idx_q <= idx_q;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end else if (last) begin
            o_q       <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StScan);
  assign done    = done_q;
  assign o       = o_q;
  assign hit     = hit_q;
  assign hit_idx = hit_idx_q;

endmodule
